// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receiver FSM encodings, default line settings and
// the baud divider calculation.
package uart_receiver_pkg;

    localparam int DEF_BAUD       = 9600;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

    // Clamped to 1 so a too-fast baud setting degrades to a tick every clock.
    function automatic int baud_div(input int clk_hz, input int baud, input int os);
        int d;
        d = clk_hz / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator, shared by the UART transmitter
// (OVERSAMPLE=1) and receiver.
module uart_baud_tick
    import uart_receiver_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = DEF_BAUD,
    parameter int OVERSAMPLE  = DEF_OVERSAMPLE
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes the RX pin, mid-bit samples on the oversample
// tick and hands each good byte to the consumer through a one-entry holding register.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = DEF_BAUD,
    parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
    parameter int DATA_BITS   = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 read_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic                 tick;
    logic [1:0]           sync_q;
    logic                 rx_s;
    rx_state_e            state_q, state_d;
    logic [SW-1:0]        s_cnt_q, s_cnt_d;
    logic [BW-1:0]        b_cnt_q, b_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 rdy_q, rdy_d;
    logic                 ovr_q, ovr_d;
    logic                 fe_q, fe_d;
    logic                 byte_done;

    uart_baud_tick #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD        (BAUD),
        .OVERSAMPLE  (OVERSAMPLE)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], rx};
    end
    assign rx_s = sync_q[1];

    always_comb begin
        state_d   = state_q;
        s_cnt_d   = s_cnt_q;
        b_cnt_d   = b_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        rdy_d     = rdy_q;
        ovr_d     = ovr_q;
        fe_d      = 1'b0;
        byte_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick && !rx_s) begin
                    state_d = ST_START;
                    s_cnt_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_cnt_q == S_HALF) begin
                        s_cnt_d = '0;
                        b_cnt_d = '0;
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_cnt_q == S_LAST) begin
                        s_cnt_d = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (b_cnt_q == B_LAST) state_d = ST_STOP;
                        else                   b_cnt_d = b_cnt_q + BW'(1);
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (s_cnt_q == S_LAST) begin
                        s_cnt_d = '0;
                        if (rx_s) begin
                            byte_done = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            fe_d    = 1'b1;
                            state_d = ST_WAIT_IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (tick && rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (read_ack) begin
            rdy_d = 1'b0;
            ovr_d = 1'b0;
        end
        // A byte landing in the same cycle as read_ack wins and is not an overrun.
        if (byte_done) begin
            data_d = shift_q;
            rdy_d  = 1'b1;
            if (rdy_q && !read_ack) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_cnt_q <= '0;
            b_cnt_q <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            ovr_q   <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            b_cnt_q <= b_cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            ovr_q   <= ovr_d;
            fe_q    <= fe_d;
        end
    end

    assign rx_data     = data_q;
    assign data_ready  = rdy_q;
    assign overrun     = ovr_q;
    assign frame_error = fe_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
